// File: rtl/fpmul_param_if.sv
// fpmul_param_if: operand/result handshake bundle for fpmul_param.
// master = operand source / result consumer, slave = the multiplier.
interface fpmul_param_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int W     = 1 + EXP_W + MAN_W
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] p;
  logic         nan_f;
  logic         inf_f;
  logic         zero_f;
  logic         of_f;
  logic         uf_f;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, p, nan_f, inf_f, zero_f, of_f, uf_f
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, p, nan_f, inf_f, zero_f, of_f, uf_f
  );
endinterface

// File: rtl/fpmul_param.sv
// fpmul_param: parametrised, self-sequenced floating-point multiplier.
// One operation at a time: IDLE -> CLASS -> MUL -> NORM -> RND -> DONE,
// or IDLE -> CLASS -> DONE for NaN/Inf/zero operands. Round-to-nearest-even,
// canonical NaN, denormal results flushed to signed zero.
// Optional feature macro: FPMUL_PARAM_DENORM_EN (denormal inputs honoured;
// without it denormal inputs are treated as signed zero).
module fpmul_param #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         rst_n,
  fpmul_param_if.slave bus
);

  localparam int PW = 2 * MAN_W + 2;  // significand product width
  localparam int EW = EXP_W + 2;      // signed internal exponent width

  localparam logic signed [EW-1:0] BIAS   = EW'(2 ** (EXP_W - 1) - 1);
  localparam logic signed [EW-1:0] EMAX   = EW'(2 ** EXP_W - 1);
  localparam logic signed [EW-1:0] ONE_E  = EW'(1);
  localparam logic signed [EW-1:0] ZERO_E = '0;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLASS = 3'd1;
  localparam logic [2:0] S_MUL   = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_RND   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]             state;
  logic [W-1:0]           ra, rb;
  logic signed [EW-1:0]   ep;
  logic [PW-1:0]          prod;
  logic [W-1:0]           p_r;
  logic [4:0]             fl_r;  // {nan, inf, zero, of, uf}

  logic                   sgn;
  logic [EXP_W-1:0]       ea_f, eb_f;
  logic [MAN_W-1:0]       ma_f, mb_f;
  logic                   nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic                   special;
  logic [W-1:0]           spec_p;
  logic [4:0]             spec_fl;
  logic [MAN_W:0]         sig_a, sig_b;
  logic [EW-1:0]          ea_eff, eb_eff;

  logic [MAN_W-1:0]       frac;
  logic                   g_bit, s_bit, inc, carry;
  logic [MAN_W-1:0]       man_r;
  logic signed [EW-1:0]   ep_r;
  logic [W-1:0]           rnd_p;
  logic [4:0]             rnd_fl;

  assign sgn  = ra[W-1] ^ rb[W-1];
  assign ea_f = ra[W-2:MAN_W];
  assign eb_f = rb[W-2:MAN_W];
  assign ma_f = ra[MAN_W-1:0];
  assign mb_f = rb[MAN_W-1:0];

  // Operand classification and the special-case result it implies.
  always_comb begin
    nan_a  = (&ea_f) & (|ma_f);
    nan_b  = (&eb_f) & (|mb_f);
    inf_a  = (&ea_f) & ~(|ma_f);
    inf_b  = (&eb_f) & ~(|mb_f);
`ifdef FPMUL_PARAM_DENORM_EN
    zero_a = ~(|ea_f) & ~(|ma_f);
    zero_b = ~(|eb_f) & ~(|mb_f);
`else
    zero_a = ~(|ea_f);
    zero_b = ~(|eb_f);
`endif
    special = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b;
    spec_p  = '0;
    spec_fl = '0;
    if (nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a)) begin
      spec_p  = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      spec_fl = 5'b10000;
    end else if (inf_a | inf_b) begin
      spec_p  = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      spec_fl = 5'b01000;
    end else begin
      spec_p  = {sgn, {(EXP_W+MAN_W){1'b0}}};
      spec_fl = 5'b00100;
    end
    // A zero exponent field means hidden bit 0 and effective exponent 1.
    sig_a  = {|ea_f, ma_f};
    sig_b  = {|eb_f, mb_f};
    ea_eff = {2'b00, ea_f[EXP_W-1:1], ea_f[0] | ~(|ea_f)};
    eb_eff = {2'b00, eb_f[EXP_W-1:1], eb_f[0] | ~(|eb_f)};
  end

`ifdef FPMUL_PARAM_DENORM_EN
  localparam int LZW = $clog2(PW);
  logic [LZW-1:0] lz;
  logic           lz_hit;

  // Leading-zero count of the product below the overflow bit.
  always_comb begin
    lz     = '0;
    lz_hit = 1'b0;
    for (int unsigned i = 0; i < PW - 1; i++) begin
      if (!lz_hit) begin
        if (prod[PW-2-i]) lz_hit = 1'b1;
        else              lz     = lz + 1'b1;
      end
    end
  end
`endif

  // Round-to-nearest-even on the normalised product and post-round exceptions.
  always_comb begin
    frac  = prod[PW-3:MAN_W];
    g_bit = prod[MAN_W-1];
    s_bit = |prod[MAN_W-2:0];
    inc   = g_bit & (s_bit | frac[0]);
    carry = inc & (&frac);
    man_r = frac + MAN_W'(inc);  // wraps to zero on carry, i.e. man = 1.0
    ep_r  = carry ? ep + ONE_E : ep;
    rnd_p  = {sgn, ep_r[EXP_W-1:0], man_r};
    rnd_fl = 5'b00000;
    if (ep_r >= EMAX) begin
      rnd_p  = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      rnd_fl = 5'b01010;
    end else if (ep_r <= ZERO_E || !prod[PW-2]) begin
      rnd_p  = {sgn, {(EXP_W+MAN_W){1'b0}}};
      rnd_fl = 5'b00101;
    end
  end

  // Control FSM plus the operand, product and result registers it sequences.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ra    <= '0;
      rb    <= '0;
      ep    <= '0;
      prod  <= '0;
      p_r   <= '0;
      fl_r  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            ra    <= bus.a;
            rb    <= bus.b;
            state <= S_CLASS;
          end
        end
        S_CLASS: begin
          if (special) begin
            p_r   <= spec_p;
            fl_r  <= spec_fl;
            state <= S_DONE;
          end else begin
            state <= S_MUL;
          end
        end
        S_MUL: begin
          ep    <= $signed(ea_eff + eb_eff) - BIAS;
          prod  <= PW'(sig_a) * PW'(sig_b);
          state <= S_NORM;
        end
        S_NORM: begin
          // Bit 0 only feeds sticky, so it is folded into bit 1 on the shift.
          if (prod[PW-1]) begin
            prod <= {1'b0, prod[PW-1:2], prod[1] | prod[0]};
            ep   <= ep + ONE_E;
          end
`ifdef FPMUL_PARAM_DENORM_EN
          else if (!prod[PW-2]) begin
            prod <= prod << lz;
            ep   <= ep - $signed(EW'(lz));
          end
`endif
          state <= S_RND;
        end
        S_RND: begin
          p_r   <= rnd_p;
          fl_r  <= rnd_fl;
          state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign bus.p         = p_r;
  assign bus.nan_f     = fl_r[4];
  assign bus.inf_f     = fl_r[3];
  assign bus.zero_f    = fl_r[2];
  assign bus.of_f      = fl_r[1];
  assign bus.uf_f      = fl_r[0];

endmodule

// File: tb/tb_fpmul_param.sv
// tb_fpmul_param: directed-vector bench for fpmul_param (default binary32).
// A value-level reference model (exact integer significand product, exact
// round-to-nearest-even) feeds a queue; one compare process checks every
// cycle that out_valid is high. Each vector also carries literal expectations.
module tb_fpmul_param;

  logic clk;
  logic rst_n;
  int   checks;
  int   passes;
  logic [36:0] exp_q[$];  // {flags[4:0], p[31:0]}
  logic [4:0]  fl;

  fpmul_param_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fpmul_param #(.EXP_W(8), .MAN_W(23)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign fl = {bus.nan_f, bus.inf_f, bus.zero_f, bus.of_f, bus.uf_f};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else passes++;
  endtask

  // Reference: product of the two encoded values, rounded to nearest-even.
  function automatic logic [36:0] model(input logic [31:0] x, input logic [31:0] y);
    int ex, ey, e, k, sh;
    longint unsigned mx, my, prod, kept, rem, half;
    logic s;
    bit nx, ny, ix, iy, zx, zy;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    mx = 64'(x[22:0]);
    my = 64'(y[22:0]);
    s  = x[31] ^ y[31];
    nx = (ex == 255) && (mx != 0);
    ny = (ey == 255) && (my != 0);
    ix = (ex == 255) && (mx == 0);
    iy = (ey == 255) && (my == 0);
`ifdef FPMUL_PARAM_DENORM_EN
    zx = (ex == 0) && (mx == 0);
    zy = (ey == 0) && (my == 0);
`else
    zx = (ex == 0);
    zy = (ey == 0);
`endif
    if (nx || ny || (ix && zy) || (iy && zx)) return {5'b10000, 32'h7FC00000};
    if (ix || iy) return {5'b01000, s, 31'h7F800000};
    if (zx || zy) return {5'b00100, s, 31'h0};
    if (ex != 0) mx = mx + (64'd1 << 23); else ex = 1;
    if (ey != 0) my = my + (64'd1 << 23); else ey = 1;
    prod = mx * my;
    k = 47;
    while (k > 0 && !prod[k]) k--;
    e  = ex + ey - 127 + (k - 46);
    sh = k - 23;
    if (sh > 0) begin
      kept = prod >> sh;
      rem  = prod & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      if (rem > half || (rem == half && kept[0])) kept = kept + 64'd1;
    end else begin
      kept = prod << (-sh);
    end
    if (kept == (64'd1 << 24)) begin
      kept = kept >> 1;
      e++;
    end
    if (e >= 255) return {5'b01010, s, 31'h7F800000};
    if (e <= 0)   return {5'b00101, s, 31'h0};
    return {5'b00000, s, e[7:0], kept[22:0]};
  endfunction

  // Compare process: every cycle a result is presented it must match the model.
  initial begin : compare
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 64'(1), 64'(0));
        end else begin
          chk("p_model", 64'(bus.p), 64'(exp_q[0][31:0]));
          chk("flags_model", 64'(fl), 64'(exp_q[0][36:32]));
          chk("in_ready_in_done", 64'(bus.in_ready), 64'(0));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // One operation; latency counts rising edges with the accept edge as the first.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] exp_p, input logic [4:0] exp_fl,
                        input int exp_lat, input int hold, input bit vld_in_done);
    int lat;
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("in_ready_idle", 64'(bus.in_ready), 64'(1));
    bus.a        = x;
    bus.b        = y;
    bus.in_valid = 1'b1;
    exp_q.push_back(model(x, y));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("in_ready_after_accept", 64'(bus.in_ready), 64'(0));
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("p_literal", 64'(bus.p), 64'(exp_p));
    chk("flags_literal", 64'(fl), 64'(exp_fl));
    if (hold > 0) begin
      repeat (hold) @(posedge clk);
      #1;
      chk("p_held", 64'(bus.p), 64'(exp_p));
      chk("flags_held", 64'(fl), 64'(exp_fl));
      chk("out_valid_held", 64'(bus.out_valid), 64'(1));
    end
    bus.out_ready = 1'b1;
    if (vld_in_done) begin
      bus.a        = 32'h3F800000;
      bus.b        = 32'h3F800000;
      bus.in_valid = 1'b1;
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    chk("out_valid_drop", 64'(bus.out_valid), 64'(0));
    chk("idle_no_accept", 64'(bus.in_ready), 64'(1));
  endtask

  initial begin : stim
    int seen;
    checks        = 0;
    passes        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_p", 64'(bus.p), 64'(0));
    chk("rst_flags", 64'(fl), 64'(0));

    run_op(32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000, 5, 0, 1'b0);
    run_op(32'h7F800000, 32'h00000000, 32'h7FC00000, 5'b10000, 2, 0, 1'b0);
    run_op(32'h7F000000, 32'h40000000, 32'h7F800000, 5'b01010, 5, 0, 1'b0);
    run_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00000, 5, 0, 1'b0);
    run_op(32'h00800000, 32'h3F000000, 32'h00000000, 5'b00101, 5, 0, 1'b0);
`ifdef FPMUL_PARAM_DENORM_EN
    run_op(32'h00400000, 32'h7F000000, 32'h3F800000, 5'b00000, 5, 0, 1'b0);
`else
    run_op(32'h00400000, 32'h7F000000, 32'h00000000, 5'b00100, 2, 0, 1'b0);
`endif
    run_op(32'h3F800001, 32'h3FC00000, 32'h3FC00002, 5'b00000, 5, 0, 1'b0);
    run_op(32'hC0000000, 32'h40400000, 32'hC0C00000, 5'b00000, 5, 0, 1'b0);
    run_op(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 5'b10000, 2, 0, 1'b0);
    run_op(32'hFF800000, 32'h40000000, 32'hFF800000, 5'b01000, 2, 0, 1'b0);
    run_op(32'h80000000, 32'h3F800000, 32'h80000000, 5'b00100, 2, 0, 1'b0);
    run_op(32'h7F7FFFFF, 32'h3F800001, 32'h7F800000, 5'b01010, 5, 0, 1'b0);
    // Backpressure in DONE, then completion with in_valid high on the same edge.
    run_op(32'h3FC00000, 32'h40000000, 32'h40400000, 5'b00000, 5, 10, 1'b1);

    // Reset pulse while the operation sits in NORM.
    bus.a        = 32'h40000000;
    bus.b        = 32'h40400000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #2;
    chk("midrst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("midrst_in_ready", 64'(bus.in_ready), 64'(1));
    chk("midrst_p", 64'(bus.p), 64'(0));
    chk("midrst_flags", 64'(fl), 64'(0));
    rst_n = 1'b1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("no_late_result", 64'(seen), 64'(0));

    run_op(32'h3F800001, 32'h3F800001, 32'h3F800002, 5'b00000, 5, 0, 1'b0);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule

// File: doc/fpmul_param.md
# fpmul_param

Parametrised, self-sequenced floating-point multiplier with a built-in control FSM and valid/ready handshakes on both sides. It generalises the fixed single-precision multiply datapath to any `EXP_W`/`MAN_W` format. It adds round-to-nearest-even, canonical NaN generation and per-result exception flags. It sits between an operand source and a result consumer in the FP unit and processes one operation at a time.

## Interface
- `EXP_W`, default 8: exponent field width; bias is `2^(EXP_W-1)-1`.
- `MAN_W`, default 23: stored mantissa field width, hidden bit excluded.
- `W`, derived `1+EXP_W+MAN_W`: operand and result width.

Ports:
- `clk` input 1: single clock, all state on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: operands A and B are presented.
- `in_ready` output 1: block accepts operands; high only in IDLE.
- `a`, `b` input W: IEEE-style operands, laid out as {sign, exp, man}.
- `out_valid` output 1: `p` and the flags are valid.
- `out_ready` input 1: consumer takes the result.
- `p` output W: product.
- `nan_f`, `inf_f`, `zero_f`, `of_f`, `uf_f` output 1 each: result classification and exception flags.

## Operation
- FSM states and transitions:
  - IDLE → CLASS on accept (`in_valid & in_ready`); operands are registered on that edge.
  - CLASS → MUL normally, or CLASS → DONE if a special case is detected.
  - MUL → NORM → RND → DONE.
  - DONE → IDLE when `out_ready`.
- CLASS: classify each operand as NaN (exp all ones, man≠0), Inf (exp all ones, man=0), zero, denormal (exp=0, man≠0) or normal.
- Special-case results:
  - Any NaN, or Inf×0 → canonical NaN: sign 0, exp all ones, man MSB set. `nan_f`=1.
  - Inf × non-zero → signed Inf. `inf_f`=1.
  - 0 × finite → signed zero. `zero_f`=1.
- Sign of every non-NaN result is `sa^sb`.
- Internal exponent is signed, `EXP_W+2` bits. MUL computes `ep = ea+eb-bias` and the full `(2·MAN_W+2)`-bit significand product.
- NORM:
  - If the product MSB is set: shift right 1, `ep+1`.
  - Otherwise, if the product is not normalised (denormal input only): left-shift by the leading-zero count and subtract that count from `ep`.
- RND: guard = first bit below the kept `MAN_W+1` bits; sticky = OR of all lower bits. Increment when `G & (S | LSB)`. A rounding carry-out renormalises: man=1.0, `ep+1`.
- Exceptions, checked after rounding:
  - `ep ≥ 2^EXP_W-1` → signed Inf, `of_f`=1, `inf_f`=1.
  - `ep ≤ 0` → signed zero, `uf_f`=1, `zero_f`=1. Denormal results are always flushed.
- `p` and the flags are loaded on entry to DONE and held until the DONE→IDLE edge. They are not cleared on leaving DONE.

## Timing
- Reset values: state IDLE; `in_ready`=1; `out_valid`=0; `p`=0; all flags 0; internal registers 0.
- Normal path: `out_valid` rises on the 5th rising edge after the accept edge.
- Special-case path: `out_valid` rises on the 2nd rising edge after the accept edge.
- `in_ready` falls on the accept edge and stays low until the DONE→IDLE edge. Throughput is at most one operation per 6 cycles (normal path).
- In DONE with `out_ready` low, `out_valid`, `p` and the flags are held stable indefinitely.
- In DONE, `in_valid` is ignored. An operation is accepted only in IDLE, so DONE&`out_ready` plus `in_valid` on the same edge produces no accept.
- `rst_n` asserted mid-operation: the FSM returns to IDLE immediately and outputs take their reset values. The in-flight operation is discarded and no result is produced.

## Configuration
- `FPMUL_PARAM_DENORM_EN`:
  - Defined: denormal inputs use hidden bit 0 and effective exponent 1. NORM's leading-zero left shift is compiled in.
  - Undefined: denormal inputs are treated as signed zero in CLASS and take the zero special path. The leading-zero logic is removed.
- Denormal outputs are flushed to zero in both builds.

## Test plan
Default parameters throughout.
- 0x3FC00000 × 0x40000000 → `p`=0x40400000, all flags 0; `out_valid` 5 edges after accept.
- 0x7F800000 × 0x00000000 → `p`=0x7FC00000, `nan_f`=1; `out_valid` 2 edges after accept.
- 0x7F000000 × 0x40000000 → `p`=0x7F800000, `of_f`=1, `inf_f`=1.
- Rounding: 0x3F800001 × 0x3F800001 → 0x3F800002, flags 0.
- Underflow: 0x00800000 × 0x3F000000 → `p`=0x00000000, `uf_f`=1, `zero_f`=1.
- Denormal input: 0x00400000 × 0x7F000000 → 0x3F800000 with the macro defined; 0x00000000 with `zero_f`=1 without it.
- Backpressure and reset:
  - Hold `out_ready`=0 for 10 cycles in DONE → `p` and flags stable, `in_ready`=0.
  - Pulse `rst_n` low during NORM → IDLE, `out_valid`=0, `p`=0, no late result.
